// File: rtl/dmem_dump_ctrl.sv
// Debug-side sequencer that dumps the whole data memory, MSB byte first, over a valid/ready byte stream.
// Optional trailing XOR checksum byte enabled by defining DMEM_DUMP_CHECKSUM_EN.
module dmem_dump_ctrl #(
    parameter int B = 32,
    parameter int W = 5
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_start,
    input  logic [B-1:0] i_debug_mem,
    input  logic         i_tx_ready,
    output logic [W-1:0] o_debug_addr,
    output logic [7:0]   o_tx_data,
    output logic         o_tx_valid,
    output logic         o_busy,
    output logic         o_done
);

    localparam int NB = B / 8;
    localparam int CW = (NB > 1) ? $clog2(NB) : 1;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_READ = 3'd1;
    localparam logic [2:0] S_SEND = 3'd2;
    localparam logic [2:0] S_DONE = 3'd4;
`ifdef DMEM_DUMP_CHECKSUM_EN
    localparam logic [2:0] S_CHK  = 3'd3;
`endif

    logic [2:0]    state;
    logic [W-1:0]  addr;
    logic [B-1:0]  shift_reg;
    logic [CW-1:0] byte_cnt;
    logic          xfer;
    logic          last_byte;
    logic          last_addr;
`ifdef DMEM_DUMP_CHECKSUM_EN
    logic [7:0]    csum;
`endif

    assign xfer      = o_tx_valid && i_tx_ready;
    assign last_byte = (byte_cnt == CW'(NB - 1));
    assign last_addr = (addr == {W{1'b1}});

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state     <= S_IDLE;
            addr      <= '0;
            shift_reg <= '0;
            byte_cnt  <= '0;
`ifdef DMEM_DUMP_CHECKSUM_EN
            csum      <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    addr <= '0;
                    if (i_start) begin
                        state <= S_READ;
`ifdef DMEM_DUMP_CHECKSUM_EN
                        csum  <= '0;
`endif
                    end
                end
                S_READ: begin
                    shift_reg <= i_debug_mem;
                    byte_cnt  <= '0;
                    state     <= S_SEND;
                end
                S_SEND: begin
                    if (xfer) begin
                        shift_reg <= shift_reg << 8;
                        byte_cnt  <= byte_cnt + CW'(1);
`ifdef DMEM_DUMP_CHECKSUM_EN
                        csum      <= csum ^ shift_reg[B-1 -: 8];
`endif
                        if (last_byte) begin
                            // The final-address test ends the walk, so the address never wraps.
                            if (last_addr) begin
`ifdef DMEM_DUMP_CHECKSUM_EN
                                state <= S_CHK;
`else
                                state <= S_DONE;
`endif
                            end else begin
                                addr  <= addr + W'(1);
                                state <= S_READ;
                            end
                        end
                    end
                end
`ifdef DMEM_DUMP_CHECKSUM_EN
                S_CHK: begin
                    if (xfer) state <= S_DONE;
                end
`endif
                S_DONE: begin
                    addr  <= '0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Outputs decode straight from state so they hold steady while the sink stalls.
`ifdef DMEM_DUMP_CHECKSUM_EN
    assign o_tx_valid = (state == S_SEND) || (state == S_CHK);
    assign o_tx_data  = (state == S_SEND) ? shift_reg[B-1 -: 8] :
                        (state == S_CHK)  ? csum : 8'h00;
`else
    assign o_tx_valid = (state == S_SEND);
    assign o_tx_data  = (state == S_SEND) ? shift_reg[B-1 -: 8] : 8'h00;
`endif
    assign o_debug_addr = addr;
    assign o_busy       = (state != S_IDLE);
    assign o_done       = (state == S_DONE);

endmodule

// File: tb/tb_dmem_dump_ctrl.sv
// Directed self-checking bench for dmem_dump_ctrl: default 32x32 instance plus a B=16, W=2 instance.
// Expectations follow DMEM_DUMP_CHECKSUM_EN when it is defined for the build.
module tb_dmem_dump_ctrl;

`ifdef DMEM_DUMP_CHECKSUM_EN
    localparam int CHK_EXTRA = 1;
`else
    localparam int CHK_EXTRA = 0;
`endif
    localparam int DONE_A = 32 * 5 + 1 + CHK_EXTRA;
    localparam int DONE_B = 4 * 3 + 1 + CHK_EXTRA;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        start_a, ready_a;
    logic [4:0]  addr_a;
    logic [7:0]  data_a;
    logic        valid_a, busy_a, done_a;
    logic [31:0] mem_a [32];
    logic [31:0] rd_a;

    logic        start_b, ready_b;
    logic [1:0]  addr_b;
    logic [7:0]  data_b;
    logic        valid_b, busy_b, done_b;
    logic [15:0] mem_b [4];
    logic [15:0] rd_b;

    assign rd_a = mem_a[addr_a];
    assign rd_b = mem_b[addr_b];

    dmem_dump_ctrl #(.B(32), .W(5)) dut_a (
        .i_clk(clk), .i_reset(rst), .i_start(start_a), .i_debug_mem(rd_a),
        .i_tx_ready(ready_a), .o_debug_addr(addr_a), .o_tx_data(data_a),
        .o_tx_valid(valid_a), .o_busy(busy_a), .o_done(done_a)
    );

    dmem_dump_ctrl #(.B(16), .W(2)) dut_b (
        .i_clk(clk), .i_reset(rst), .i_start(start_b), .i_debug_mem(rd_b),
        .i_tx_ready(ready_b), .o_debug_addr(addr_b), .o_tx_data(data_b),
        .o_tx_valid(valid_b), .o_busy(busy_b), .o_done(done_b)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Stream monitors sample mid-cycle, well away from the active edge.
    logic [7:0] q_a [$];
    logic [7:0] q_b [$];
    logic [7:0] exp_q [$];
    int   done_cnt_a = 0;
    int   done_cnt_b = 0;
    int   unstable_a = 0;
    logic prev_stall = 1'b0;
    logic [7:0] prev_data = 8'h00;

    always @(negedge clk) begin
        if (valid_a && ready_a) q_a.push_back(data_a);
        if (valid_b && ready_b) q_b.push_back(data_b);
        if (done_a) done_cnt_a++;
        if (done_b) done_cnt_b++;
        if (prev_stall && (!valid_a || data_a !== prev_data)) unstable_a++;
        prev_stall = valid_a && !ready_a;
        prev_data  = data_a;
    end

    function automatic void build_exp_a();
        logic [7:0] acc;
        logic [31:0] w;
        acc = 8'h00;
        exp_q.delete();
        for (int k = 0; k < 32; k++) begin
            w = mem_a[k];
            for (int b = 0; b < 4; b++) begin
                exp_q.push_back(w[31-8*b -: 8]);
                acc = acc ^ w[31-8*b -: 8];
            end
        end
        if (CHK_EXTRA == 1) exp_q.push_back(acc);
    endfunction

    task automatic compare_stream(input string tag);
        check({tag, "_len"}, q_a.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < q_a.size()) check($sformatf("%s_b%0d", tag, i), q_a[i], exp_q[i]);
        end
    endtask

    task automatic run_dump_a(input int mode, input bit mid_start, output int done_cyc, output int busy_drop);
        int  cyc;
        bit  injected;
        q_a.delete();
        done_cnt_a = 0;
        unstable_a = 0;
        busy_drop  = 0;
        done_cyc   = 0;
        injected   = 1'b0;
        @(posedge clk); #1;
        start_a = 1'b1;
        ready_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        cyc = 0;
        while (1) begin
            if (!busy_a) busy_drop++;
            if (done_a) begin
                done_cyc = cyc + 1;
                break;
            end
            if (cyc >= 2000) break;
            if (mode == 0) ready_a = 1'b1;
            else ready_a = (((4'b1001 >> (cyc % 4)) & 4'b0001) != 0) ^ ($urandom_range(0, 7) == 0);
            start_a = 1'b0;
            if (mid_start && !injected && q_a.size() == 10) begin
                start_a  = 1'b1;
                injected = 1'b1;
            end
            @(posedge clk); #1;
            cyc++;
        end
        start_a = 1'b0;
        ready_a = 1'b1;
        @(posedge clk); #1;
        check("done_drop", done_a, 0);
        check("idle_busy", busy_a, 0);
        check("idle_addr", addr_a, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int dc, bd, cyc;
        logic [7:0] exp_b [$];
        logic [7:0] acc_b;

        rst = 1'b1; start_a = 1'b0; ready_a = 1'b1; start_b = 1'b0; ready_b = 1'b1;
        for (int k = 0; k < 32; k++) mem_a[k] = 32'hA500_0000 | k;
        mem_b[0] = 16'h1234; mem_b[1] = 16'h5678; mem_b[2] = 16'h9ABC; mem_b[3] = 16'hDEF0;
        #12;
        check("rst_addr", addr_a, 0);
        check("rst_data", data_a, 0);
        check("rst_valid", valid_a, 0);
        check("rst_busy", busy_a, 0);
        check("rst_done", done_a, 0);
        @(negedge clk) rst = 1'b0;

        // Full dump, ready always high.
        run_dump_a(0, 1'b0, dc, bd);
        build_exp_a();
        compare_stream("full");
        check("full_done_cyc", dc, DONE_A);
        check("full_done_cnt", done_cnt_a, 1);
        check("full_busy", bd, 0);

        // Back-pressure.
        run_dump_a(1, 1'b0, dc, bd);
        compare_stream("bp");
        check("bp_stable", unstable_a, 0);
        check("bp_done_cnt", done_cnt_a, 1);
        check("bp_busy", bd, 0);

        // Start pulsed while busy must not restart the walk.
        run_dump_a(0, 1'b1, dc, bd);
        compare_stream("busy_start");
        check("busy_start_done_cyc", dc, DONE_A);
        check("busy_start_done_cnt", done_cnt_a, 1);

        // Reset asserted while word 7 byte 2 is on the bus.
        q_a.delete();
        done_cnt_a = 0;
        @(posedge clk); #1 start_a = 1'b1;
        @(posedge clk); #1 start_a = 1'b0;
        cyc = 0;
        while (q_a.size() < 30 && cyc < 1000) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("rst_reach", q_a.size(), 30);
        check("rst_pre_data", data_a, 8'h00);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_addr", addr_a, 0);
        check("mid_rst_data", data_a, 0);
        check("mid_rst_valid", valid_a, 0);
        check("mid_rst_busy", busy_a, 0);
        check("mid_rst_done", done_a, 0);
        @(negedge clk) rst = 1'b0;
        check("mid_rst_no_done", done_cnt_a, 0);
        run_dump_a(0, 1'b0, dc, bd);
        check("restart_first", q_a.size() > 0 ? q_a[0] : 8'hxx, 8'hA5);
        compare_stream("restart");
        check("restart_done_cyc", dc, DONE_A);

        // Sparse memory: checksum (when enabled) equals word 0 low byte.
        for (int k = 0; k < 32; k++) mem_a[k] = 32'h0;
        mem_a[0] = 32'h0102_0304;
        run_dump_a(0, 1'b0, dc, bd);
        build_exp_a();
        compare_stream("sparse");
        check("sparse_done_cyc", dc, DONE_A);
        if (CHK_EXTRA == 1 && q_a.size() == 129) check("sparse_csum", q_a[128], 8'h04);

        // Narrow instance: B=16, W=2.
        exp_b = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
        acc_b = 8'h00;
        foreach (exp_b[i]) acc_b = acc_b ^ exp_b[i];
        if (CHK_EXTRA == 1) exp_b.push_back(acc_b);
        q_b.delete();
        done_cnt_b = 0;
        @(posedge clk); #1 start_b = 1'b1;
        @(posedge clk); #1 start_b = 1'b0;
        dc = 0;
        cyc = 0;
        while (cyc < 500) begin
            if (done_b) begin
                dc = cyc + 1;
                break;
            end
            @(posedge clk); #1;
            cyc++;
        end
        check("narrow_done_cyc", dc, DONE_B);
        check("narrow_len", q_b.size(), exp_b.size());
        for (int i = 0; i < exp_b.size(); i++) begin
            if (i < q_b.size()) check($sformatf("narrow_b%0d", i), q_b[i], exp_b[i]);
        end
        @(posedge clk); #1;
        check("narrow_done_cnt", done_cnt_b, 1);
        check("narrow_idle", busy_b, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
